// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup, flush and issue signals of the ALU issue queue.
// The queue connects through the slave modport; its driver uses master.
interface alu_issue_queue_if;
    logic       flush_i;
    logic       disp0_valid_i;
    logic [4:0] disp0_rob_i;
    logic [5:0] disp0_rs1_i;
    logic [5:0] disp0_rs2_i;
    logic       disp0_rs1_rdy_i;
    logic       disp0_rs2_rdy_i;
    logic       disp1_valid_i;
    logic [4:0] disp1_rob_i;
    logic [5:0] disp1_rs1_i;
    logic [5:0] disp1_rs2_i;
    logic       disp1_rs1_rdy_i;
    logic       disp1_rs2_rdy_i;
    logic       disp_ready_o;
    logic       wb0_valid_i;
    logic [5:0] wb0_dest_i;
    logic       wb1_valid_i;
    logic [5:0] wb1_dest_i;
    logic       alu0_valid_o;
    logic [4:0] alu0_rob_o;
    logic [5:0] alu0_rs1_o;
    logic [5:0] alu0_rs2_o;
    logic       alu0_ready_i;
    logic       alu1_valid_o;
    logic [4:0] alu1_rob_o;
    logic [5:0] alu1_rs1_o;
    logic [5:0] alu1_rs2_o;
    logic       alu1_ready_i;

    modport slave (
        input  flush_i,
        input  disp0_valid_i, disp0_rob_i, disp0_rs1_i, disp0_rs2_i, disp0_rs1_rdy_i, disp0_rs2_rdy_i,
        input  disp1_valid_i, disp1_rob_i, disp1_rs1_i, disp1_rs2_i, disp1_rs1_rdy_i, disp1_rs2_rdy_i,
        output disp_ready_o,
        input  wb0_valid_i, wb0_dest_i, wb1_valid_i, wb1_dest_i,
        output alu0_valid_o, alu0_rob_o, alu0_rs1_o, alu0_rs2_o,
        input  alu0_ready_i,
        output alu1_valid_o, alu1_rob_o, alu1_rs1_o, alu1_rs2_o,
        input  alu1_ready_i
    );

    modport master (
        output flush_i,
        output disp0_valid_i, disp0_rob_i, disp0_rs1_i, disp0_rs2_i, disp0_rs1_rdy_i, disp0_rs2_rdy_i,
        output disp1_valid_i, disp1_rob_i, disp1_rs1_i, disp1_rs2_i, disp1_rs1_rdy_i, disp1_rs2_rdy_i,
        input  disp_ready_o,
        output wb0_valid_i, wb0_dest_i, wb1_valid_i, wb1_dest_i,
        input  alu0_valid_o, alu0_rob_o, alu0_rs1_o, alu0_rs2_o,
        output alu0_ready_i,
        input  alu1_valid_o, alu1_rob_o, alu1_rs1_o, alu1_rs2_o,
        output alu1_ready_i
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue for the two integer ALU pipes: tracks operand
// readiness via writeback wakeups and picks the two oldest ready entries per cycle.
module alu_issue_queue #(
    parameter int unsigned DEPTH = 8
) (
    input logic               cpu_clk_i,
    input logic               cpu_rst_i,
    alu_issue_queue_if.slave  q_if
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CNTW = IDXW + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_rdy1;
    logic [DEPTH-1:0] r_rdy2;
    logic [4:0]       r_rob   [DEPTH];
    logic [5:0]       r_rs1   [DEPTH];
    logic [5:0]       r_rs2   [DEPTH];
    logic [DEPTH-1:0] r_older [DEPTH];

    logic             w_wb0_v, w_wb1_v;
    logic [5:0]       w_wb0_d, w_wb1_d;
    logic [DEPTH-1:0] w_elig, w_elig1;
    logic             w_pick0_found, w_pick1_found;
    logic [IDXW-1:0]  w_pick0, w_pick1;
    logic             w_alu0_valid, w_alu1_valid;
    logic [DEPTH-1:0] w_free_mask;
    logic [CNTW-1:0]  w_nfree;
    logic             w_disp_ready, w_accept;
    logic             w_found_a, w_found_b;
    logic [IDXW-1:0]  w_first, w_second;
    logic             w_alloc0, w_alloc1;
    logic [IDXW-1:0]  w_idx0, w_idx1;
    logic [DEPTH-1:0] w_alloc0_mask, w_alloc1_mask;

    assign w_wb0_v = q_if.wb0_valid_i;
    assign w_wb1_v = q_if.wb1_valid_i;
    assign w_wb0_d = q_if.wb0_dest_i;
    assign w_wb1_d = q_if.wb1_dest_i;

    function automatic logic wb_hit(input logic [5:0] tag);
        return (w_wb0_v && (w_wb0_d == tag)) || (w_wb1_v && (w_wb1_d == tag));
    endfunction

    // Tag 0 is hardwired ready; same-cycle writeback bypasses into the new entry.
    function automatic logic src_rdy(input logic [5:0] tag, input logic rdy_in);
        return (tag == 6'd0) || rdy_in || wb_hit(tag);
    endfunction

    assign w_elig = r_valid & r_rdy1 & r_rdy2;

    // Oldest-ready select: an entry wins when no eligible entry in its age row remains.
    always_comb begin
        w_pick0_found = 1'b0;
        w_pick0       = '0;
        w_pick1_found = 1'b0;
        w_pick1       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_elig[i] && ((w_elig & r_older[i]) == '0)) begin
                w_pick0_found = 1'b1;
                w_pick0       = IDXW'(i);
            end
        end
        w_elig1 = w_elig;
        if (w_pick0_found) w_elig1[w_pick0] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_elig1[i] && ((w_elig1 & r_older[i]) == '0)) begin
                w_pick1_found = 1'b1;
                w_pick1       = IDXW'(i);
            end
        end
    end

    assign w_alu0_valid = w_pick0_found && !q_if.flush_i;
    assign w_alu1_valid = w_pick1_found && !q_if.flush_i;

    assign q_if.alu0_valid_o = w_alu0_valid;
    assign q_if.alu0_rob_o   = w_alu0_valid ? r_rob[w_pick0] : 5'd0;
    assign q_if.alu0_rs1_o   = w_alu0_valid ? r_rs1[w_pick0] : 6'd0;
    assign q_if.alu0_rs2_o   = w_alu0_valid ? r_rs2[w_pick0] : 6'd0;
    assign q_if.alu1_valid_o = w_alu1_valid;
    assign q_if.alu1_rob_o   = w_alu1_valid ? r_rob[w_pick1] : 5'd0;
    assign q_if.alu1_rs1_o   = w_alu1_valid ? r_rs1[w_pick1] : 6'd0;
    assign q_if.alu1_rs2_o   = w_alu1_valid ? r_rs2[w_pick1] : 6'd0;

    // Free count and allocation slots come from registered valid bits only.
    always_comb begin
        w_free_mask = '0;
        if (w_alu0_valid && q_if.alu0_ready_i) w_free_mask[w_pick0] = 1'b1;
        if (w_alu1_valid && q_if.alu1_ready_i) w_free_mask[w_pick1] = 1'b1;
        w_nfree   = '0;
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        w_first   = '0;
        w_second  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i]) begin
                w_nfree = w_nfree + CNTW'(1);
                if (!w_found_a) begin
                    w_found_a = 1'b1;
                    w_first   = IDXW'(i);
                end else if (!w_found_b) begin
                    w_found_b = 1'b1;
                    w_second  = IDXW'(i);
                end
            end
        end
    end

    assign w_disp_ready      = (w_nfree >= CNTW'(2));
    assign q_if.disp_ready_o = w_disp_ready;
    assign w_accept          = w_disp_ready && !q_if.flush_i;
    assign w_alloc0          = w_accept && q_if.disp0_valid_i;
    assign w_alloc1          = w_accept && q_if.disp1_valid_i;
    assign w_idx0            = w_first;
    assign w_idx1            = q_if.disp0_valid_i ? w_second : w_first;
    assign w_alloc0_mask     = w_alloc0 ? (DEPTH'(1) << w_idx0) : '0;
    assign w_alloc1_mask     = w_alloc1 ? (DEPTH'(1) << w_idx1) : '0;

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i]   <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
                r_older[i] <= '0;
            end
        end else if (q_if.flush_i) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && wb_hit(r_rs1[i])) r_rdy1[i] <= 1'b1;
                if (r_valid[i] && wb_hit(r_rs2[i])) r_rdy2[i] <= 1'b1;
                if (w_free_mask[i]) r_valid[i] <= 1'b0;
                if (w_alloc0_mask[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_rob[i]    <= q_if.disp0_rob_i;
                    r_rs1[i]    <= q_if.disp0_rs1_i;
                    r_rs2[i]    <= q_if.disp0_rs2_i;
                    r_rdy1[i]   <= src_rdy(q_if.disp0_rs1_i, q_if.disp0_rs1_rdy_i);
                    r_rdy2[i]   <= src_rdy(q_if.disp0_rs2_i, q_if.disp0_rs2_rdy_i);
                    r_older[i]  <= r_valid & ~w_free_mask;
                end else if (w_alloc1_mask[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_rob[i]    <= q_if.disp1_rob_i;
                    r_rs1[i]    <= q_if.disp1_rs1_i;
                    r_rs2[i]    <= q_if.disp1_rs2_i;
                    r_rdy1[i]   <= src_rdy(q_if.disp1_rs1_i, q_if.disp1_rs1_rdy_i);
                    r_rdy2[i]   <= src_rdy(q_if.disp1_rs2_i, q_if.disp1_rs2_rdy_i);
                    r_older[i]  <= (r_valid & ~w_free_mask) | w_alloc0_mask;
                end else begin
                    // New arrivals are younger than every surviving entry.
                    r_older[i]  <= r_older[i] & ~(w_alloc0_mask | w_alloc1_mask);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: single issue, wakeup, full queue,
// partial ready, dispatch bypass and flush scenarios.
module tb_alu_issue_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_queue_if ifc ();

    alu_issue_queue #(.DEPTH(8)) dut (
        .cpu_clk_i (clk),
        .cpu_rst_i (rst),
        .q_if      (ifc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_disp();
        ifc.disp0_valid_i = 0; ifc.disp0_rob_i = 0; ifc.disp0_rs1_i = 0; ifc.disp0_rs2_i = 0;
        ifc.disp0_rs1_rdy_i = 0; ifc.disp0_rs2_rdy_i = 0;
        ifc.disp1_valid_i = 0; ifc.disp1_rob_i = 0; ifc.disp1_rs1_i = 0; ifc.disp1_rs2_i = 0;
        ifc.disp1_rs1_rdy_i = 0; ifc.disp1_rs2_rdy_i = 0;
    endtask

    task automatic idle_inputs();
        clear_disp();
        ifc.flush_i = 0;
        ifc.wb0_valid_i = 0; ifc.wb0_dest_i = 0;
        ifc.wb1_valid_i = 0; ifc.wb1_dest_i = 0;
        ifc.alu0_ready_i = 0; ifc.alu1_ready_i = 0;
    endtask

    task automatic set_disp0(input logic [4:0] rob, input logic [5:0] rs1, input logic r1,
                             input logic [5:0] rs2, input logic r2);
        ifc.disp0_valid_i = 1; ifc.disp0_rob_i = rob; ifc.disp0_rs1_i = rs1;
        ifc.disp0_rs1_rdy_i = r1; ifc.disp0_rs2_i = rs2; ifc.disp0_rs2_rdy_i = r2;
    endtask

    task automatic set_disp1(input logic [4:0] rob, input logic [5:0] rs1, input logic r1,
                             input logic [5:0] rs2, input logic r2);
        ifc.disp1_valid_i = 1; ifc.disp1_rob_i = rob; ifc.disp1_rs1_i = rs1;
        ifc.disp1_rs1_rdy_i = r1; ifc.disp1_rs2_i = rs2; ifc.disp1_rs2_rdy_i = r2;
    endtask

    task automatic flush_all();
        ifc.flush_i = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        n_tests++; if (ifc.alu0_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_alu0_valid got %0b exp 0", ifc.alu0_valid_o); end
        n_tests++; if (ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_alu1_valid got %0b exp 0", ifc.alu1_valid_o); end
        n_tests++; if (ifc.alu0_rob_o !== 5'd0 || ifc.alu1_rob_o !== 5'd0) begin n_fail++; $display("FAIL reset_rob got %0d/%0d exp 0/0", ifc.alu0_rob_o, ifc.alu1_rob_o); end
        n_tests++; if (ifc.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %0b exp 1", ifc.disp_ready_o); end
    endtask

    task automatic test_single_issue();
        set_disp0(5'd3, 6'd0, 1'b0, 6'd5, 1'b1);
        tick();
        clear_disp();
        n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'd3) begin n_fail++; $display("FAIL single_pick0 got v=%0b rob=%0d exp v=1 rob=3", ifc.alu0_valid_o, ifc.alu0_rob_o); end
        n_tests++; if (ifc.alu0_rs1_o !== 6'd0 || ifc.alu0_rs2_o !== 6'd5) begin n_fail++; $display("FAIL single_tags got %0d/%0d exp 0/5", ifc.alu0_rs1_o, ifc.alu0_rs2_o); end
        n_tests++; if (ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_alu1_idle got %0b exp 0", ifc.alu1_valid_o); end
        ifc.alu0_ready_i = 1;
        tick();
        ifc.alu0_ready_i = 0;
        n_tests++; if (ifc.alu0_valid_o !== 1'b0 || ifc.alu0_rob_o !== 5'd0) begin n_fail++; $display("FAIL single_freed got v=%0b rob=%0d exp v=0 rob=0", ifc.alu0_valid_o, ifc.alu0_rob_o); end
    endtask

    task automatic test_wakeup();
        set_disp0(5'd4, 6'd9, 1'b0, 6'd0, 1'b0);
        tick();
        set_disp0(5'd6, 6'd1, 1'b1, 6'd2, 1'b1);
        tick();
        clear_disp();
        n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'd6) begin n_fail++; $display("FAIL wake_ready_first got v=%0b rob=%0d exp v=1 rob=6", ifc.alu0_valid_o, ifc.alu0_rob_o); end
        n_tests++; if (ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_unready_held got %0b exp 0", ifc.alu1_valid_o); end
        ifc.alu0_ready_i = 1;
        tick();
        ifc.alu0_ready_i = 0;
        ifc.wb0_valid_i = 1; ifc.wb0_dest_i = 6'd9;
        #1;
        n_tests++; if (ifc.alu0_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle got %0b exp 0", ifc.alu0_valid_o); end
        tick();
        ifc.wb0_valid_i = 0; ifc.wb0_dest_i = 0;
        n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'd4 || ifc.alu0_rs1_o !== 6'd9) begin n_fail++; $display("FAIL wake_issue got v=%0b rob=%0d rs1=%0d exp v=1 rob=4 rs1=9", ifc.alu0_valid_o, ifc.alu0_rob_o, ifc.alu0_rs1_o); end
        flush_all();
    endtask

    task automatic test_fill();
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (ifc.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got %0b exp 1", c, ifc.disp_ready_o); end
            set_disp0(5'(2 * c), 6'd12, 1'b0, 6'd0, 1'b0);
            set_disp1(5'(2 * c + 1), 6'd12, 1'b0, 6'd0, 1'b0);
            tick();
        end
        clear_disp();
        n_tests++; if (ifc.disp_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full got %0b exp 0", ifc.disp_ready_o); end
        n_tests++; if (ifc.alu0_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_none_ready got %0b exp 0", ifc.alu0_valid_o); end
        ifc.wb0_valid_i = 1; ifc.wb0_dest_i = 6'd12;
        tick();
        ifc.wb0_valid_i = 0; ifc.wb0_dest_i = 0;
        ifc.alu0_ready_i = 1; ifc.alu1_ready_i = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'(2 * k)) begin n_fail++; $display("FAIL fill_pick0_%0d got v=%0b rob=%0d exp rob=%0d", k, ifc.alu0_valid_o, ifc.alu0_rob_o, 2 * k); end
            n_tests++; if (ifc.alu1_valid_o !== 1'b1 || ifc.alu1_rob_o !== 5'(2 * k + 1)) begin n_fail++; $display("FAIL fill_pick1_%0d got v=%0b rob=%0d exp rob=%0d", k, ifc.alu1_valid_o, ifc.alu1_rob_o, 2 * k + 1); end
            if (k == 1) begin
                n_tests++; if (ifc.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_reopen got %0b exp 1", ifc.disp_ready_o); end
            end
            tick();
        end
        ifc.alu0_ready_i = 0; ifc.alu1_ready_i = 0;
        n_tests++; if (ifc.alu0_valid_o !== 1'b0 || ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_drained got %0b/%0b exp 0/0", ifc.alu0_valid_o, ifc.alu1_valid_o); end
    endtask

    task automatic test_partial_ready();
        set_disp0(5'd10, 6'd0, 1'b0, 6'd0, 1'b0);
        set_disp1(5'd11, 6'd3, 1'b1, 6'd4, 1'b1);
        tick();
        clear_disp();
        ifc.alu0_ready_i = 0; ifc.alu1_ready_i = 1;
        n_tests++; if (ifc.alu0_rob_o !== 5'd10 || ifc.alu1_rob_o !== 5'd11) begin n_fail++; $display("FAIL partial_picks got %0d/%0d exp 10/11", ifc.alu0_rob_o, ifc.alu1_rob_o); end
        tick();
        ifc.alu1_ready_i = 0;
        n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'd10) begin n_fail++; $display("FAIL partial_redrive got v=%0b rob=%0d exp v=1 rob=10", ifc.alu0_valid_o, ifc.alu0_rob_o); end
        n_tests++; if (ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL partial_alu1_freed got %0b exp 0", ifc.alu1_valid_o); end
        flush_all();
    endtask

    task automatic test_bypass();
        set_disp0(5'd13, 6'd0, 1'b0, 6'd7, 1'b0);
        set_disp1(5'd14, 6'd0, 1'b0, 6'd8, 1'b0);
        ifc.wb1_valid_i = 1; ifc.wb1_dest_i = 6'd7;
        tick();
        clear_disp();
        ifc.wb1_valid_i = 0; ifc.wb1_dest_i = 0;
        n_tests++; if (ifc.alu0_valid_o !== 1'b1 || ifc.alu0_rob_o !== 5'd13 || ifc.alu0_rs2_o !== 6'd7) begin n_fail++; $display("FAIL bypass_issue got v=%0b rob=%0d rs2=%0d exp v=1 rob=13 rs2=7", ifc.alu0_valid_o, ifc.alu0_rob_o, ifc.alu0_rs2_o); end
        n_tests++; if (ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_nomatch got %0b exp 0", ifc.alu1_valid_o); end
        flush_all();
    endtask

    task automatic test_flush();
        set_disp0(5'd20, 6'd0, 1'b0, 6'd0, 1'b0);
        set_disp1(5'd21, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        set_disp0(5'd22, 6'd0, 1'b0, 6'd0, 1'b0);
        set_disp1(5'd23, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        clear_disp();
        set_disp0(5'd24, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        clear_disp();
        n_tests++; if (ifc.alu0_rob_o !== 5'd20 || ifc.alu1_rob_o !== 5'd21 || ifc.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre got %0d/%0d rdy=%0b exp 20/21 rdy=1", ifc.alu0_rob_o, ifc.alu1_rob_o, ifc.disp_ready_o); end
        ifc.flush_i = 1;
        set_disp0(5'd25, 6'd0, 1'b0, 6'd0, 1'b0);
        set_disp1(5'd26, 6'd0, 1'b0, 6'd0, 1'b0);
        #1;
        n_tests++; if (ifc.alu0_valid_o !== 1'b0 || ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_mask got %0b/%0b exp 0/0", ifc.alu0_valid_o, ifc.alu1_valid_o); end
        tick();
        idle_inputs();
        n_tests++; if (ifc.alu0_valid_o !== 1'b0 || ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %0b/%0b exp 0/0", ifc.alu0_valid_o, ifc.alu1_valid_o); end
        n_tests++; if (ifc.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_disp_ready got %0b exp 1", ifc.disp_ready_o); end
        set_disp0(5'd27, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        clear_disp();
        n_tests++; if (ifc.alu0_rob_o !== 5'd27 || ifc.alu1_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_refill got rob=%0d v1=%0b exp rob=27 v1=0", ifc.alu0_rob_o, ifc.alu1_valid_o); end
        flush_all();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        test_reset();
        test_single_issue();
        test_wakeup();
        test_fill();
        test_partial_ready();
        test_bypass();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached before completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Out-of-order issue queue for the two integer ALU pipes. It sits between rename/dispatch and the per-ROB instruction payload RAM. It holds ROB ids of dispatched ALU micro-ops together with their physical source tags, and tracks operand readiness through writeback wakeups. Each cycle it selects up to two oldest-ready entries and drives their 5-bit ROB ids to the ALU pipes, which use them to index the payload RAM.

## Interface
- DEPTH, 8, number of queue entries (power of two, 4..16)
- cpu_clk_i  in  1  clock
- cpu_rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; invalidates every entry
- disp0_valid_i / disp1_valid_i  in  1  dispatch slot valid
- disp0_rob_i / disp1_rob_i  in  5  ROB id ({pack_id, slot})
- disp0_rs1_i, disp0_rs2_i / disp1_rs1_i, disp1_rs2_i  in  6  physical source tags
- disp0_rs1_rdy_i, disp0_rs2_rdy_i / disp1_rs1_rdy_i, disp1_rs2_rdy_i  in  1  source already ready at rename
- disp_ready_o  out  1  queue can accept two micro-ops this cycle
- wb0_valid_i / wb1_valid_i  in  1  wakeup broadcast valid
- wb0_dest_i / wb1_dest_i  in  6  physical tag becoming ready
- alu0_valid_o / alu1_valid_o  out  1  issue valid
- alu0_rob_o / alu1_rob_o  out  5  issued ROB id (payload RAM read index)
- alu0_rs1_o, alu0_rs2_o / alu1_rs1_o, alu1_rs2_o  out  6  issued source tags (register-file read)
- alu0_ready_i / alu1_ready_i  in  1  pipe accepts the issue this cycle

## Operation
- Per-entry state: valid, rob[4:0], rs1, rs2, rdy1, rdy2, plus an age matrix where older[i][j]=1 means j is older than i.
- Entry i is eligible when valid && rdy1 && rdy2.
- Tag 0 is always ready: any source tag of 0 is stored with rdy=1, regardless of the input rdy bit.
- Dispatch:
  - Accepted only when disp_ready_o=1. Slots with valid=0 are ignored.
  - disp0 takes the lowest-index free entry; disp1 takes the next-lowest. If disp0 is invalid, disp1 takes the lowest.
  - On allocation, the new entry's age row is set to the current valid vector (minus entries freed this cycle). If both slots are valid, disp1 also marks disp0's entry as older.
- Dispatch/wakeup bypass: a source tag matching a same-cycle valid wbN_dest_i is stored ready.
- Wakeup: every valid entry whose rs1/rs2 matches a valid wb tag sets the matching rdy bit at the clock edge. Both wb ports act independently; the same tag on both ports is legal.
- Select:
  - pick0 is the eligible entry with no eligible older entry, and drives the alu0 outputs.
  - pick1 is the oldest eligible entry excluding pick0, and drives the alu1 outputs.
  - Selection never depends on aluN_ready_i (no combinational loop).
- Issue:
  - An entry is freed at the edge where its pipe's valid && ready are both high.
  - An unaccepted pick stays valid and is re-selected the next cycle, unless an older entry becomes eligible.
- disp_ready_o = (free entries ≥ 2), computed from registered state only; frees in the same cycle are not counted.
- Flush: all valid bits clear at the edge. Dispatch in the flush cycle is discarded. alu0/alu1_valid_o are forced low combinationally while flush_i=1.
- When aluN_valid_o=0, aluN_rob_o and aluN_rs*_o are driven to 0.

## Timing
- Reset values: all entries invalid; alu0/1_valid_o=0; all issue data outputs 0; disp_ready_o=1 in the first cycle after reset deassertion.
- Dispatch at edge N with both sources ready: the entry can issue in cycle N+1 (one-cycle minimum dispatch-to-issue).
- Wakeup presented in cycle N: dependent entries become eligible in cycle N+1.
- Issue outputs are combinational from registered state in the same cycle. The free takes effect at the next edge.
- Full queue: disp_ready_o=0 while fewer than 2 entries are free. Upstream holds its inputs.
- Simultaneous events in one cycle are all legal: issue-free of entry i, allocation of a different entry, and wakeup. A freed entry cannot be reallocated in the same edge.
- Reset or flush asserted mid-operation overrides dispatch, wakeup and issue in that cycle.

## Test plan
- Reset, then dispatch rob 3 (rs1=0, rs2=5, rdy2=1) on disp0 only -> next cycle alu0_valid_o=1, alu0_rob_o=3, alu1_valid_o=0; with alu0_ready_i=1 the entry frees, and the following cycle alu0_valid_o=0.
- Dispatch rob 4 (rs1=9, not ready) then rob 6 (both ready) -> rob 6 issues on alu0. Drive wb0_dest_i=9 -> rob 4 issues on alu0 in the next cycle.
- Fill 8 entries with unready sources (tag 12) over 4 cycles -> disp_ready_o=0 after the 7th/8th allocation. Broadcast tag 12 -> the two oldest issue (alu0 older than alu1) each cycle for 4 cycles.
- Two eligible entries with alu0_ready_i=0, alu1_ready_i=1 -> only the alu1 pick frees. The alu0 pick stays and is re-driven next cycle.
- Dispatch with rs2=7 in the same cycle as wb1_dest_i=7 -> the entry issues the next cycle without any further wakeup.
- Queue holding 5 entries, flush_i=1 while dispatching 2 -> alu*_valid_o=0 that cycle, next cycle queue is empty, disp_ready_o=1, no issue.
